// File: rtl/mux2to1_rr_arbiter.sv
// rtl/mux2to1_rr_arbiter.sv - round-robin arbiter sharing one registered k-bit output between requesters V and W
// The grant drives the mux select; the chosen word is held in a one-entry output buffer.
module mux2to1_rr_arbiter #(
  parameter int k     = 8,
  parameter int BURST = 1
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [k-1:0] V,
  input  logic         V_valid,
  output logic         V_ready,
  input  logic [k-1:0] W,
  input  logic         W_valid,
  output logic         W_ready,
  output logic [k-1:0] F,
  output logic         F_valid,
  input  logic         F_ready,
  output logic         Sel
);

  localparam int            CW   = $clog2(BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(BURST);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic          last;
  logic [CW-1:0] cnt;
  logic          load;
  logic          g;

  // cnt==0 means no burst is in progress, so after reset !last (V) wins first
  always_comb begin
    g = 1'b0;
    if (V_valid && !W_valid) begin
      g = 1'b0;
    end else if (W_valid && !V_valid) begin
      g = 1'b1;
    end else if (V_valid && W_valid) begin
      g = ((cnt != '0) && (cnt < CMAX)) ? last : !last;
    end
  end

  assign load    = ((state == EMPTY) || F_ready) && (V_valid || W_valid);
  assign V_ready = Resetn && load && !g;
  assign W_ready = Resetn && load && g;
  assign F_valid = (state == FULL);

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (F_ready && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= EMPTY;
      F     <= '0;
      Sel   <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        F    <= g ? W : V;
        Sel  <= g;
        last <= g;
        if (g == last) begin
          cnt <= (cnt == CMAX) ? cnt : cnt + ONE;
        end else begin
          cnt <= ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux2to1_rr_arbiter.sv
// tb/tb_mux2to1_rr_arbiter.sv - scoreboard bench for mux2to1_rr_arbiter with BURST=1 and BURST=2 instances
module tb_mux2to1_rr_arbiter;

  logic       clk;
  logic       resetn;
  logic [7:0] v [2];
  logic [7:0] w [2];
  logic [7:0] f [2];
  logic       v_valid [2];
  logic       w_valid [2];
  logic       f_ready [2];
  logic       v_ready [2];
  logic       w_ready [2];
  logic       f_valid [2];
  logic       sel [2];

  // reference state: grant history, expected words, directed expectations, buffer occupancy
  logic       hist [2][$];
  logic [8:0] expq [2][$];
  logic [8:0] dq   [2][$];
  logic       full [2];

  int errors = 0;
  int checks = 0;
  bit done   = 0;

  mux2to1_rr_arbiter #(.k(8), .BURST(1)) u_dut_b1 (
    .Clock(clk), .Resetn(resetn),
    .V(v[0]), .V_valid(v_valid[0]), .V_ready(v_ready[0]),
    .W(w[0]), .W_valid(w_valid[0]), .W_ready(w_ready[0]),
    .F(f[0]), .F_valid(f_valid[0]), .F_ready(f_ready[0]), .Sel(sel[0])
  );

  mux2to1_rr_arbiter #(.k(8), .BURST(2)) u_dut_b2 (
    .Clock(clk), .Resetn(resetn),
    .V(v[1]), .V_valid(v_valid[1]), .V_ready(v_ready[1]),
    .W(w[1]), .W_valid(w_valid[1]), .W_ready(w_ready[1]),
    .F(f[1]), .F_valid(f_valid[1]), .F_ready(f_ready[1]), .Sel(sel[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int burst_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function void chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endfunction

  function void fail_now(input string name, input int i);
    checks++;
    errors++;
    $display("FAIL %s dut%0d: got event expected none at %0t", name, i, $time);
  endfunction

  // grant from the round-robin rules: count the current run of identical grants
  function automatic logic model_grant(input int i, input logic vv, input logic wv);
    logic lst;
    int   run;
    if (vv && !wv) return 1'b0;
    if (wv && !vv) return 1'b1;
    if (hist[i].size() == 0) return 1'b0;
    lst = hist[i][$];
    run = 0;
    for (int n = hist[i].size() - 1; n >= 0; n--) begin
      if (hist[i][n] != lst || run >= burst_of(i)) break;
      run++;
    end
    return (run < burst_of(i)) ? lst : !lst;
  endfunction

  function automatic void step(input int i);
    logic       ld;
    logic       g;
    logic       cons;
    logic [8:0] got;
    logic [8:0] e;
    chk("f_valid", i, f_valid[i], full[i]);
    cons = full[i] && f_ready[i];
    if (cons) begin
      got = {sel[i], f[i]};
      if (expq[i].size() == 0) begin
        fail_now("unexpected_word", i);
      end else begin
        e = expq[i].pop_front();
        chk("word", i, got, e);
      end
      if (dq[i].size() != 0) begin
        e = dq[i].pop_front();
        chk("directed_word", i, got, e);
      end
    end
    ld = (!full[i] || f_ready[i]) && (v_valid[i] || w_valid[i]);
    g  = model_grant(i, v_valid[i], w_valid[i]);
    chk("v_ready", i, v_ready[i], ld && !g);
    chk("w_ready", i, w_ready[i], ld && g);
    if (ld) begin
      expq[i].push_back({g, g ? w[i] : v[i]});
      hist[i].push_back(g);
      if (hist[i].size() > 8) hist[i].delete(0);
      full[i] = 1'b1;
    end else if (cons) begin
      full[i] = 1'b0;
    end
  endfunction

  initial begin : monitor
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!resetn) begin
          chk("reset_f_valid", i, f_valid[i], 1'b0);
          chk("reset_f", i, f[i], 8'd0);
          chk("reset_sel", i, sel[i], 1'b0);
          chk("reset_v_ready", i, v_ready[i], 1'b0);
          chk("reset_w_ready", i, w_ready[i], 1'b0);
          hist[i].delete();
          expq[i].delete();
          full[i] = 1'b0;
        end else begin
          step(i);
        end
      end
      if (done || cyc > 20000) begin
        if (!done) fail_now("timeout", 0);
        for (int i = 0; i < 2; i++) begin
          chk("leftover_expected", i, expq[i].size(), 0);
          chk("leftover_directed", i, dq[i].size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set(input int i, input logic vv, input logic [7:0] vd,
                     input logic wv, input logic [7:0] wd, input logic fr);
    v_valid[i] = vv;
    v[i]       = vd;
    w_valid[i] = wv;
    w[i]       = wd;
    f_ready[i] = fr;
  endtask

  task automatic pulse_reset;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  // producers hold valid/data until their ready has been seen
  task automatic rand_run(input int i, input int n);
    logic av;
    logic aw;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      av = v_ready[i];
      aw = w_ready[i];
      @(posedge clk);
      #1;
      if (!v_valid[i] || av) begin
        v_valid[i] = ($urandom_range(0, 3) != 0);
        v[i]       = 8'($urandom);
      end
      if (!w_valid[i] || aw) begin
        w_valid[i] = ($urandom_range(0, 3) != 0);
        w[i]       = 8'($urandom);
      end
      f_ready[i] = ($urandom_range(0, 3) != 0);
    end
    set(i, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    repeat (3) tick();
  endtask

  initial begin
    resetn = 1'b0;
    set(0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    set(1, 1'b1, 8'h33, 1'b1, 8'h44, 1'b1);
    repeat (3) tick();
    resetn = 1'b1;
    set(0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    set(1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1);

    // single source
    set(0, 1'b1, 8'd3, 1'b0, 8'd0, 1'b1);
    dq[0].push_back({1'b0, 8'd3});
    tick();
    set(0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    repeat (2) tick();

    // contention with BURST=1 strictly alternates, V first after reset
    pulse_reset();
    set(0, 1'b1, 8'd3, 1'b1, 8'd5, 1'b1);
    dq[0].push_back({1'b0, 8'd3});
    dq[0].push_back({1'b1, 8'd5});
    dq[0].push_back({1'b0, 8'd3});
    dq[0].push_back({1'b1, 8'd5});
    repeat (4) tick();
    set(0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    repeat (2) tick();

    // back-pressure holds F=7 while W waits
    set(0, 1'b1, 8'd7, 1'b0, 8'd0, 1'b0);
    dq[0].push_back({1'b0, 8'd7});
    tick();
    set(0, 1'b0, 8'd0, 1'b1, 8'd2, 1'b0);
    repeat (3) tick();
    set(0, 1'b0, 8'd0, 1'b1, 8'd2, 1'b1);
    dq[0].push_back({1'b1, 8'd2});
    tick();
    set(0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    repeat (2) tick();

    // BURST=2 pairs, then W drops and V keeps every grant
    pulse_reset();
    set(1, 1'b1, 8'd9, 1'b1, 8'd1, 1'b1);
    dq[1].push_back({1'b0, 8'd9});
    dq[1].push_back({1'b0, 8'd9});
    dq[1].push_back({1'b1, 8'd1});
    dq[1].push_back({1'b1, 8'd1});
    dq[1].push_back({1'b0, 8'd9});
    dq[1].push_back({1'b0, 8'd9});
    repeat (6) tick();
    set(1, 1'b1, 8'd9, 1'b0, 8'd0, 1'b1);
    repeat (3) dq[1].push_back({1'b0, 8'd9});
    repeat (3) tick();
    set(1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    repeat (2) tick();

    // reset while F holds 4: word dropped, V wins next contention
    set(1, 1'b1, 8'd4, 1'b0, 8'd0, 1'b0);
    tick();
    set(1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    #1;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    set(1, 1'b1, 8'd6, 1'b1, 8'd7, 1'b1);
    dq[1].push_back({1'b0, 8'd6});
    dq[1].push_back({1'b1, 8'd7});
    tick();
    set(1, 1'b0, 8'd0, 1'b1, 8'd7, 1'b1);
    tick();
    set(1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    repeat (2) tick();

    rand_run(0, 600);
    rand_run(1, 600);
    done = 1'b1;
  end

endmodule
